des_sp_stage: RTL

DES_SP_STAGE -- requirements
Module: des_sp_stage

---
 rtl/des_pkg.sv | 49 ++++
 rtl/des_sbox.sv | 25 ++
 rtl/des_sp_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg -- shared constants for the DES S-box / P-permutation stage.
//   state_e      : FSM states of des_sp_stage (IDLE, SUB, DONE)
//   P_TABLE      : DES P permutation, output bit i takes s bit P_TABLE[i]
//   SBOX_TABLE   : the eight DES S-boxes, 64 x 4-bit entries each, packed
//                  so that entry e = {row, col} sits in nibble e counted
//                  from the most significant end
//   sbox_lookup  : reads one S-box entry for a 6-bit chunk
// Bit numbering follows DES: bit 1 is the most significant bit.
// -----------------------------------------------------------------------------
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [5:0] P_TABLE [1:32] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // One 256-bit word per S-box; each group of 16 hex digits is one row.
  localparam logic [255:0] SBOX_TABLE [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // box0 is the zero-based box number; chunk[5] is the first (MSB) bit.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box0,
                                             input logic [5:0] chunk);
    logic [5:0]   idx;
    logic [255:0] tbl;
    // Row comes from the outer bits, column from the inner four.
    idx = {chunk[5], chunk[0], chunk[4:1]};
    tbl = SBOX_TABLE[box0];
    return tbl[(8'd252 - {idx, 2'b00}) +: 4];
  endfunction

endpackage

// File: rtl/des_sbox.sv
// -----------------------------------------------------------------------------
// des_sbox -- combinational lookup of one DES S-box.
//   box_i   [3:0] : S-box number, 1..8 (anything else yields 0)
//   chunk_i [5:0] : 6-bit input chunk, chunk_i[5] is the DES MSB
//   sbox_o  [3:0] : 4-bit S-box output, sbox_o[3] is the DES MSB
// -----------------------------------------------------------------------------
module des_sbox
  import des_pkg::*;
(
  input  logic [3:0] box_i,
  input  logic [5:0] chunk_i,
  output logic [3:0] sbox_o
);

  // Table lookup, guarded against out-of-range box numbers.
  always_comb begin
    sbox_o = 4'd0;
    if ((box_i >= 4'd1) && (box_i <= 4'd8)) begin
      sbox_o = sbox_lookup(3'(box_i - 4'd1), chunk_i);
    end else begin
      sbox_o = 4'd0;
    end
  end

endmodule

// File: rtl/des_sp_stage.sv
// -----------------------------------------------------------------------------
// des_sp_stage -- DES f-function back end: P(S(data_in XOR key_in)).
// Evaluates LANES S-boxes per cycle, so a result takes 8/LANES cycles.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : upstream offers data_in/key_in
//   in_ready    : block is idle and will accept
//   data_in     : [1:48] expanded half-block, bit 1 = MSB
//   key_in      : [1:48] round subkey, bit 1 = MSB
//   out_valid   : data_out holds a completed result
//   out_ready   : downstream takes data_out
//   data_out    : [1:32] f-function result, bit 1 = MSB
// -----------------------------------------------------------------------------
module des_sp_stage
  import des_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:48] data_in,
  input  logic [1:48] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:32] data_out
);

  if ((LANES != 1) && (LANES != 2) && (LANES != 4) && (LANES != 8)) begin : g_bad_lanes
    $error("des_sp_stage: LANES must be 1, 2, 4 or 8");
  end

  localparam int         GROUPS   = 8 / LANES;
  localparam logic [2:0] LAST_CNT = 3'(GROUPS - 1);
  // LANES=8 wraps to 0 here; harmless because cnt is then always 0.
  localparam logic [2:0] LANES_W  = 3'(LANES % 8);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [1:48] x_q;
  logic [1:32] s_q;
  logic [1:32] s_d;
  logic [1:32] data_out_q;
  logic [1:32] data_out_d;
  logic        out_valid_q;

  logic [5:0]  x_chunk_s  [0:7];
  logic [3:0]  lane_out_s [0:LANES-1];

  // Split x into its eight 6-bit chunks.
  for (genvar j = 0; j < 8; j++) begin : g_chunk
    assign x_chunk_s[j] = x_q[6*j+1 +: 6];
  end

  // Lane l handles box cnt*LANES + l (zero-based) in the current group.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [2:0] box0_s;
    assign box0_s = 3'(cnt_q * LANES_W) + 3'(l);

    des_sbox u_sbox (
      .box_i   ({1'b0, box0_s} + 4'd1),
      .chunk_i (x_chunk_s[box0_s]),
      .sbox_o  (lane_out_s[l])
    );
  end

  // Nibble j is overwritten only while its group is active.
  for (genvar j = 0; j < 8; j++) begin : g_nib
    assign s_d[4*j+1 +: 4] = (cnt_q == 3'(j / LANES)) ? lane_out_s[j % LANES]
                                                     : s_q[4*j+1 +: 4];
  end

  // P permutation of the fully updated s value.
  for (genvar i = 1; i <= 32; i++) begin : g_perm
    assign data_out_d[i] = s_d[int'(P_TABLE[i])];
  end

  // Control FSM with the datapath registers it owns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      x_q         <= 48'h0;
      s_q         <= 32'h0;
      data_out_q  <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q     <= data_in ^ key_in;
            cnt_q   <= 3'd0;
            state_q <= ST_SUB;
          end
        end
        ST_SUB: begin
          s_q <= s_d;
          if (cnt_q == LAST_CNT) begin
            data_out_q  <= data_out_d;
            out_valid_q <= 1'b1;
            cnt_q       <= 3'd0;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= 3'd0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Masked by rst so nothing is offered as acceptable while reset is held.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule
